// File: rtl/aes_pkg.sv
// aes_pkg: GF(2^8) helpers and FSM state type shared by the AES MixColumns datapath
package aes_pkg;
    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mulB(input logic [7:0] b);
        logic [7:0] x2;
        x2 = xtime(b);
        return xtime(xtime(x2)) ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mulD(input logic [7:0] b);
        logic [7:0] x4;
        x4 = xtime(xtime(b));
        return xtime(x4) ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mulE(input logic [7:0] b);
        logic [7:0] x2, x4;
        x2 = xtime(b);
        x4 = xtime(x2);
        return xtime(x4) ^ x4 ^ x2;
    endfunction
endpackage

// File: rtl/mix_single_column.sv
// mix_single_column: combinational forward/inverse MixColumns on one 32-bit column (row 0 in the MSB)
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);
    logic [7:0] a [4];

    assign a = '{col_in[31:24], col_in[23:16], col_in[15:8], col_in[7:0]};

    // Each output row is the row-0 coefficients rotated, so row r starts at a[r]
    always_comb begin
        col_out = '0;
        for (int r = 0; r < 4; r++)
            col_out[31-8*r -: 8] = inv
                ? gf_mulE(a[r]) ^ gf_mulB(a[(r+1)%4]) ^ gf_mulD(a[(r+2)%4]) ^ gf_mul9(a[(r+3)%4])
                : gf_mul2(a[r]) ^ gf_mul3(a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: handshaked MixColumns/InvMixColumns engine mixing COLS_PER_CYCLE columns per clock
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         inv_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    localparam int NUM_STEPS = 4 / COLS_PER_CYCLE;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_e    st;
    logic [1:0]   cnt;
    logic [127:0] work;
    logic         inv_q;
    logic [1:0]   idx     [COLS_PER_CYCLE];
    logic [31:0]  col_in  [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    // Column c occupies bits [127-32c -: 32]; {~c, 5'h1f} is that top bit
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign idx[g]    = 2'(int'(cnt) * COLS_PER_CYCLE + g);
        assign col_in[g] = work[{~idx[g], 5'h1f} -: 32];
        mix_single_column u_mix (
            .col_in  (col_in[g]),
            .inv     (inv_q),
            .col_out (col_out[g])
        );
    end

    assign in_ready  = st == ST_IDLE;
    assign out_valid = st == ST_DONE;
    assign busy      = st != ST_IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_IDLE;
            cnt       <= '0;
            state_out <= '0;
            work      <= '0;
            inv_q     <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: if (in_valid) begin
                    work  <= state_in;
                    inv_q <= inv_in;
                    cnt   <= '0;
                    st    <= ST_BUSY;
                end
                ST_BUSY: begin
                    for (int j = 0; j < COLS_PER_CYCLE; j++)
                        state_out[{~idx[j], 5'h1f} -: 32] <= col_out[j];
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'(NUM_STEPS - 1))
                        st <= ST_DONE;
                end
                ST_DONE: if (out_ready) st <= ST_IDLE;
                default: st <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: checks 1/2/4-column builds against a matrix-multiply reference model
module tb_mix_columns_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] state_in  [3];
    logic         inv_in    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] state_out [3];
    logic         busy      [3];
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    // Instance g mixes (1 << g) columns per clock
    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .state_in  (state_in[g]),
            .inv_in    (inv_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .state_out (state_out[g]),
            .busy      (busy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p ^= 16'(a) << i;
        for (int i = 15; i >= 8; i--)
            if (p[i]) p ^= 16'h11B << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   m [4];
        logic [7:0]   acc;
        logic [127:0] r = '0;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(m[k], s[127 - 8*(4*c + (row + k) % 4) -: 8]);
                r[127 - 8*(4*c + row) -: 8] = acc;
            end
        return r;
    endfunction

    // Starts on a negedge with the instance idle; returns on the negedge where out_valid is seen
    task automatic issue(input int k, input logic [127:0] d, input logic inv,
                         output int lat, output bit bad);
        in_valid[k] = 1'b1;
        state_in[k] = d;
        inv_in[k]   = inv;
        @(negedge clk);
        in_valid[k] = 1'b0;
        state_in[k] = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        bad = 1'b0;
        while (out_valid[k] !== 1'b1 && lat < 20) begin
            if (in_ready[k] !== 1'b0 || busy[k] !== 1'b1) bad = 1'b1;
            out_ready[k] = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            inv_in[k]    = 1'b0;
            state_in[k]  = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks += 4;
            if (in_ready[k] !== 1'b1) begin failures++; $display("FAIL reset_in_ready k=%0d got=%b exp=1", k, in_ready[k]); end
            if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL reset_out_valid k=%0d got=%b exp=0", k, out_valid[k]); end
            if (busy[k] !== 1'b0) begin failures++; $display("FAIL reset_busy k=%0d got=%b exp=0", k, busy[k]); end
            if (state_out[k] !== 128'h0) begin failures++; $display("FAIL reset_state_out k=%0d got=%h exp=0", k, state_out[k]); end
        end
    endtask

    task automatic test_vectors();
        logic [127:0] vin  [2] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'hd4d4d4d5_2d26314c_d4bf5d30_01010101};
        logic [127:0] vout [2] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hd5d5d7d6_4d7ebdf8_046681e5_01010101};
        logic [127:0] d, exp;
        int lat;
        bit bad;
        for (int k = 0; k < 3; k++)
            for (int v = 0; v < 4; v++) begin
                d   = v[0] ? vout[v/2] : vin[v/2];
                exp = v[0] ? vin[v/2] : vout[v/2];
                issue(k, d, v[0], lat, bad);
                checks += 4;
                if (lat != (4 >> k)) begin failures++; $display("FAIL vec_latency k=%0d v=%0d got=%0d exp=%0d", k, v, lat, 4 >> k); end
                if (bad) begin failures++; $display("FAIL vec_busy_handshake k=%0d v=%0d in_ready/busy wrong while busy", k, v); end
                if (state_out[k] !== exp) begin failures++; $display("FAIL vec_result k=%0d v=%0d got=%h exp=%h", k, v, state_out[k], exp); end
                out_ready[k] = 1'b1;
                @(negedge clk);
                out_ready[k] = 1'b0;
                if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0) begin
                    failures++;
                    $display("FAIL vec_release k=%0d v=%0d got in_ready=%b out_valid=%b exp 1/0", k, v, in_ready[k], out_valid[k]);
                end
            end
    endtask

    task automatic test_backpressure(input int k);
        logic [127:0] d = 128'h00112233_44556677_8899aabb_ccddeeff;
        logic [127:0] exp;
        int lat;
        bit bad, stall_bad = 1'b0;
        exp = ref_mix(d, 1'b0);
        issue(k, d, 1'b0, lat, bad);
        in_valid[k] = 1'b1;
        state_in[k] = ~d;
        inv_in[k]   = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0 || state_out[k] !== exp) stall_bad = 1'b1;
        end
        checks += 4;
        if (stall_bad) begin failures++; $display("FAIL bp_hold k=%0d got=%h exp=%h held with out_valid=1 in_ready=0", k, state_out[k], exp); end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        if (in_ready[k] !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready k=%0d got=%b exp=1", k, in_ready[k]); end
        if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid k=%0d got=%b exp=0", k, out_valid[k]); end
        @(negedge clk);
        if (busy[k] !== 1'b0) begin failures++; $display("FAIL bp_no_capture k=%0d busy got=%b exp=0", k, busy[k]); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        int lat;
        bit bad, rose = 1'b0;
        in_valid[0] = 1'b1;
        state_in[0] = d;
        inv_in[0]   = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 5;
        if (out_valid[0] !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid[0]); end
        if (state_out[0] !== 128'h0) begin failures++; $display("FAIL rstmid_state_out got=%h exp=0", state_out[0]); end
        if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready[0]); end
        repeat (6) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0) rose = 1'b1;
        end
        if (rose) begin failures++; $display("FAIL rstmid_partial got out_valid=1 exp=0 after abandon"); end
        issue(0, d, 1'b0, lat, bad);
        if (state_out[0] !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6) begin
            failures++;
            $display("FAIL rstmid_next_result got=%h exp=8e4da1bc9fdc589d01010101c6c6c6c6", state_out[0]);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
    endtask

    task automatic test_random(input int k, input int n);
        logic [127:0] q [$];
        logic [127:0] d, exp, held;
        logic inv;
        int lat;
        bit bad, stall_bad;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid[k]  = 1'b0;
                state_in[k]  = {$urandom, $urandom, $urandom, $urandom};
                inv_in[k]    = 1'($urandom);
                out_ready[k] = 1'($urandom);
                @(negedge clk);
            end
            checks++;
            if (in_ready[k] !== 1'b1) begin failures++; $display("FAIL rnd_idle k=%0d i=%0d in_ready got=%b exp=1", k, i, in_ready[k]); end
            d   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom);
            q.push_back(ref_mix(d, inv));
            issue(k, d, inv, lat, bad);
            checks += 4;
            if (lat != (4 >> k) || bad) begin failures++; $display("FAIL rnd_latency k=%0d i=%0d got=%0d exp=%0d busy_err=%b", k, i, lat, 4 >> k, bad); end
            held = state_out[k];
            stall_bad = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                if (out_valid[k] !== 1'b1 || state_out[k] !== held) stall_bad = 1'b1;
            end
            if (stall_bad) begin failures++; $display("FAIL rnd_stall k=%0d i=%0d got=%h exp=%h", k, i, state_out[k], held); end
            exp = q.pop_front();
            if (state_out[k] !== exp) begin failures++; $display("FAIL rnd_result k=%0d i=%0d inv=%b got=%h exp=%h", k, i, inv, state_out[k], exp); end
            out_ready[k] = 1'b1;
            @(negedge clk);
            out_ready[k] = 1'b0;
            if (out_valid[k] !== 1'b0) begin failures++; $display("FAIL rnd_single_output k=%0d i=%0d out_valid got=%b exp=0", k, i, out_valid[k]); end
        end
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL rnd_outstanding k=%0d got=%0d exp=0", k, q.size()); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure(2);
        test_backpressure(0);
        test_reset_mid();
        fork
            test_random(2, 10000);
            test_random(1, 3000);
            test_random(0, 3000);
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
